// File: rtl/ppu_pkg.sv
// Shared PPU pipeline definitions: forwarding select encodings, hazard FSM
// states and the architectural PC register specifier.
package ppu_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // R15 reads always come from next_pc and never participate in hazards
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic {
    HZ_RUN,
    HZ_BUBBLE
  } hz_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_forwarding_unit_if.sv
// Pipeline-register fields seen by the hazard unit and the control it returns.
interface hazard_forwarding_unit_if;

  logic [3:0]  id_ra, id_rb, id_rd;
  logic        id_use_a, id_use_b, id_use_d;
  logic [3:0]  ex_rd;
  logic        ex_rf_en, ex_load;
  logic [3:0]  mem_rd;
  logic        mem_rf_en;
  logic [3:0]  wb_rd;
  logic        wb_rf_en;
  logic        branch_taken;

  logic        pc_le, ifid_le, nop_sel, ifid_flush;
  logic [1:0]  fwd_a, fwd_b, fwd_d;
  logic [15:0] stall_count, flush_count;

  modport master (
    output id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d,
           ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en, wb_rd, wb_rf_en,
           branch_taken,
    input  pc_le, ifid_le, nop_sel, ifid_flush, fwd_a, fwd_b, fwd_d,
           stall_count, flush_count
  );

  modport slave (
    input  id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d,
           ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en, wb_rd, wb_rf_en,
           branch_taken,
    output pc_le, ifid_le, nop_sel, ifid_flush, fwd_a, fwd_b, fwd_d,
           stall_count, flush_count
  );

endinterface

// File: rtl/forward_sel.sv
// Per-operand forwarding source select; nearest producing stage wins.
module forward_sel
  import ppu_pkg::*;
(
  input  logic [3:0] spec,
  input  logic       use_en,
  input  logic [3:0] ex_rd,
  input  logic       ex_rf_en,
  input  logic       ex_load,
  input  logic [3:0] mem_rd,
  input  logic       mem_rf_en,
  input  logic [3:0] wb_rd,
  input  logic       wb_rf_en,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (use_en && spec != REG_PC) begin
      // A load in EX has no data yet; the load-use stall covers that case
      if (ex_rf_en && !ex_load && ex_rd == spec)
        sel = FWD_EX;
      else if (mem_rf_en && mem_rd == spec)
        sel = FWD_MEM;
      else if (wb_rf_en && wb_rd == spec)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// ID-stage hazard controller: operand forwarding, one-bubble load-use stall,
// taken-branch IF/ID flush and saturating debug counters.
module hazard_forwarding_unit
  import ppu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  hazard_forwarding_unit_if.slave  hz
);

  hz_state_e   state;
  logic        hazard, stall, flush;
  logic [1:0]  sel_a, sel_b, sel_d;
  logic [15:0] stall_cnt, flush_cnt;

  function automatic logic dep(input logic [3:0] spec, input logic use_en,
                               input logic [3:0] rd);
    return use_en && spec != REG_PC && spec == rd;
  endfunction

  forward_sel u_fwd_a (
    .spec(hz.id_ra), .use_en(hz.id_use_a),
    .ex_rd(hz.ex_rd), .ex_rf_en(hz.ex_rf_en), .ex_load(hz.ex_load),
    .mem_rd(hz.mem_rd), .mem_rf_en(hz.mem_rf_en),
    .wb_rd(hz.wb_rd), .wb_rf_en(hz.wb_rf_en), .sel(sel_a)
  );

  forward_sel u_fwd_b (
    .spec(hz.id_rb), .use_en(hz.id_use_b),
    .ex_rd(hz.ex_rd), .ex_rf_en(hz.ex_rf_en), .ex_load(hz.ex_load),
    .mem_rd(hz.mem_rd), .mem_rf_en(hz.mem_rf_en),
    .wb_rd(hz.wb_rd), .wb_rf_en(hz.wb_rf_en), .sel(sel_b)
  );

  forward_sel u_fwd_d (
    .spec(hz.id_rd), .use_en(hz.id_use_d),
    .ex_rd(hz.ex_rd), .ex_rf_en(hz.ex_rf_en), .ex_load(hz.ex_load),
    .mem_rd(hz.mem_rd), .mem_rf_en(hz.mem_rf_en),
    .wb_rd(hz.wb_rd), .wb_rf_en(hz.wb_rf_en), .sel(sel_d)
  );

  assign hazard = hz.ex_load && hz.ex_rf_en &&
                  (dep(hz.id_ra, hz.id_use_a, hz.ex_rd) ||
                   dep(hz.id_rb, hz.id_use_b, hz.ex_rd) ||
                   dep(hz.id_rd, hz.id_use_d, hz.ex_rd));

  // A taken branch squashes the dependent instruction, so it overrides the stall
  assign stall = !reset && state == HZ_RUN && hazard && !hz.branch_taken;
  assign flush = !reset && hz.branch_taken;

  assign hz.pc_le       = !stall;
  assign hz.ifid_le     = !stall;
  assign hz.nop_sel     = stall;
  assign hz.ifid_flush  = flush;
  assign hz.fwd_a       = reset ? FWD_RF : sel_a;
  assign hz.fwd_b       = reset ? FWD_RF : sel_b;
  assign hz.fwd_d       = reset ? FWD_RF : sel_d;
  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HZ_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        HZ_RUN:    if (stall) state <= HZ_BUBBLE;
        HZ_BUBBLE: state <= HZ_RUN;
        default:   state <= HZ_RUN;
      endcase
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: doc/hazard_forwarding_unit.md
# hazard_forwarding_unit

Pipeline hazard controller for the PPU five-stage core (IF, ID, EX, MEM, WB). Sits beside the ID stage. It reads register specifiers from the IF/ID register and destination and enable fields from the ID/EX, EX/MEM and MEM/WB registers. From these it drives:
- the PC and IF/ID load enables,
- the control-unit NOP mux select,
- the IF/ID flush,
- three operand forwarding selects.

It detects load-use hazards, holds the front end for exactly one bubble, squashes the fetched instruction on a taken branch, and keeps saturating stall and flush counters for debug.

## Interface
- No parameters. Register specifier width is fixed at 4; counter width is fixed at 16.
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_ra, id_rb, id_rd  in  4 each  source specifiers of the instruction in ID (rd is the store-data source)
- id_use_a, id_use_b, id_use_d  in  1 each  the ID instruction actually reads that operand
- ex_rd  in  4  destination in ID/EX
- ex_rf_en  in  1  EX instruction writes the register file
- ex_load  in  1  EX instruction is a load
- mem_rd, mem_rf_en  in  4, 1  EX/MEM destination and write enable
- wb_rd, wb_rf_en  in  4, 1  MEM/WB destination and write enable
- branch_taken  in  1  branch in ID resolved taken this cycle
- pc_le  out  1  PC load enable
- ifid_le  out  1  IF/ID load enable
- nop_sel  out  1  1 = control-unit mux forces all control signals to 0
- ifid_flush  out  1  clears IF/ID on the next edge
- fwd_a, fwd_b, fwd_d  out  2 each  operand source: 00 register file, 01 EX result, 10 MEM result, 11 WB data
- stall_count, flush_count  out  16 each  saturating event counters

## Operation
- **Forwarding.** Forwarding is combinational and evaluated per operand X in {a, b, d}, skipped when id_use_X=0 or the specifier equals 15. R15 is always sourced from next_pc. Matches are checked in this priority order:
  - EX, when ex_rf_en=1, ex_load=0 and ex_rd matches → 01;
  - otherwise MEM, when mem_rf_en=1 and mem_rd matches → 10;
  - otherwise WB, when wb_rf_en=1 and wb_rd matches → 11;
  - otherwise → 00.
- **Load-use hazard.** A hazard exists when ex_load=1, ex_rf_en=1, and ex_rd equals any used, non-R15 ID specifier.
- **FSM states.** RUN and BUBBLE.
  - RUN: on a hazard with branch_taken=0, drive pc_le=0, ifid_le=0 and nop_sel=1 in the same cycle, then go to BUBBLE. Otherwise all three stay at their run values (1, 1, 0).
  - BUBBLE: drive pc_le=1, ifid_le=1 and nop_sel=0 unconditionally. The load is now in MEM, so it forwards through 10. Always return to RUN. A hazard is never re-detected in BUBBLE, because ex_load is 0 for the injected NOP.
- **Flush.** branch_taken=1 drives ifid_flush=1 for that cycle, with pc_le=1.
- **Branch and hazard in the same cycle.** The flush wins: no stall, nop_sel=0, and the FSM stays in RUN.
- **Counters.**
  - stall_count increments on every RUN→BUBBLE transition.
  - flush_count increments on every cycle with ifid_flush=1.
  - Both saturate at 16'hFFFF.
- **Reset.**
  - While reset=1: pc_le=1, ifid_le=1, nop_sel=0, ifid_flush=0 and fwd_*=00, regardless of inputs.
  - On the first edge with reset=1: FSM returns to RUN and both counters clear to 0.
  - Reset during BUBBLE aborts the bubble; the state after reset is RUN.

## Timing
- Forwarding selects have zero latency; they are combinational from the current pipeline-register outputs.
- A stall is asserted in the same cycle the hazard is visible and lasts exactly 1 cycle per load-use pair. Back-to-back dependent loads give 1 bubble each.
- State and counter updates are visible 1 cycle after the triggering event.
- A flush is a single-cycle pulse. A branch_taken held for N cycles gives N flushes and N counts.

## Structure
- Shared package ppu_pkg holds:
  - fwd encodings FWD_RF, FWD_EX, FWD_MEM, FWD_WB;
  - the state enum HZ_RUN, HZ_BUBBLE;
  - the constant REG_PC = 4'd15.
- One sub-module, forward_sel, instanced three times (a, b, d). It takes a specifier, a use bit and the three stage destination/enable pairs, and returns the 2-bit select.

## Test plan
- **Reset.** Hold reset for 2 cycles with random inputs → all outputs at reset values. Release reset → stall_count=0, flush_count=0, FSM in RUN.
- **Forwarding priority.** id_ra=3, id_use_a=1; ex_rd=mem_rd=wb_rd=3, all rf_en=1, ex_load=0 → fwd_a=01. Drop ex_rf_en → 10. Also drop mem_rf_en → 11. id_ra=15 → 00.
- **Load-use.** ex_load=1, ex_rd=5, id_rb=5, id_use_b=1 → that cycle pc_le=0, ifid_le=0, nop_sel=1. Next cycle (ex_load=0, mem_rd=5) → pc_le=1, nop_sel=0, fwd_b=10, stall_count=1.
- **Branch plus hazard.** Load-use hazard present with branch_taken=1 → ifid_flush=1, nop_sel=0, pc_le=1, FSM stays in RUN, flush_count increments, stall_count unchanged.
- **Saturation.** Force 65,537 flush cycles → flush_count holds at 16'hFFFF.
- **Reset mid-bubble.** Trigger a stall, assert reset during BUBBLE → next cycle FSM is in RUN with pc_le=1 and both counters 0.
